// File: rtl/generate_set_of_mux_pkg.sv
// Shared constants for the registered word-select stage.
// Holds the default word width and the reset value of the output register.
package generate_set_of_mux_pkg;

    localparam int MUX_WIDTH_DEFAULT = 4;
    localparam int MUX_WIDTH_MAX     = 64;

    // Zero-filled at the widest legal width; each user slices it down to WIDTH.
    localparam logic [MUX_WIDTH_MAX-1:0] MUX_RST_VAL = '0;

endpackage

// File: rtl/generate_set_of_mux_if.sv
// Word-select bus: two candidate words and a shared select go in.
// The registered selected word comes back out. Index 0 of every word is its MSB.
interface generate_set_of_mux_if
    import generate_set_of_mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEFAULT
);

    logic [0:WIDTH-1] a;
    logic [0:WIDTH-1] b;
    logic             sel;
    logic [0:WIDTH-1] f;

    modport master (output a, output b, output sel, input f);
    modport slave  (input a, input b, input sel, output f);

endinterface

// File: rtl/generate_set_of_mux_mux2.sv
// Single-bit combinational 2:1 mux cell.
// An unknown sel yields X only where a and b differ.
module mux2 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/generate_set_of_mux.sv
// Registered word-select stage: one mux2 cell per bit with a shared select.
// The selected word is registered once, so latency is a single cycle.
module generate_set_of_mux
    import generate_set_of_mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    generate_set_of_mux_if.slave bus
);

    localparam logic [0:WIDTH-1] RST_VAL = MUX_RST_VAL[WIDTH-1:0];

    logic [0:WIDTH-1] m;

    // Bits never interact, so each one gets its own cell.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : gen_mux
            mux2 u_mux2 (
                .a   (bus.a[i]),
                .b   (bus.b[i]),
                .sel (bus.sel),
                .y   (m[i])
            );
        end
    endgenerate

    // Output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.f <= RST_VAL;
        end else begin
            bus.f <= m;
        end
    end

endmodule

// File: tb/tb_generate_set_of_mux.sv
// Bench for generate_set_of_mux at WIDTH 4, 1 and 8.
// A per-cycle reference (rst ? 0 : sel ? b : a, one edge late) is checked alongside directed literals.
module tb_generate_set_of_mux;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    bit   has_exp;

    logic [0:3] e4;
    logic [0:0] e1;
    logic [0:7] e8;

    generate_set_of_mux_if #(.WIDTH(4)) if4 ();
    generate_set_of_mux_if #(.WIDTH(1)) if1 ();
    generate_set_of_mux_if #(.WIDTH(8)) if8 ();

    generate_set_of_mux #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    generate_set_of_mux #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    generate_set_of_mux #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: whatever was presented at an edge is what f shows after it.
    always @(posedge clk) begin
        e4      <= rst ? 4'b0 : (if4.sel ? if4.b : if4.a);
        e1      <= rst ? 1'b0 : (if1.sel ? if1.b : if1.a);
        e8      <= rst ? 8'b0 : (if8.sel ? if8.b : if8.a);
        has_exp <= 1'b1;
    end

    always @(negedge clk) begin
        if (has_exp) begin
            check("model_w4", 64'(if4.f), 64'(e4));
            check("model_w1", 64'(if1.f), 64'(e1));
            check("model_w8", 64'(if8.f), 64'(e8));
        end
    end

    // Drive the WIDTH=4 instance, then wait until just after the next edge.
    task automatic apply4(input logic r, input logic [0:3] aa, input logic [0:3] bb, input logic s);
        rst    = r;
        if4.a  = aa;
        if4.b  = bb;
        if4.sel = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        has_exp = 1'b0;
        rst     = 1'b1;
        if4.a = '0; if4.b = '0; if4.sel = 1'b0;
        if1.a = '0; if1.b = '0; if1.sel = 1'b0;
        if8.a = '0; if8.b = '0; if8.sel = 1'b0;

        // Reset held for two edges, then released
        apply4(1'b1, 4'b1011, 4'b1111, 1'b1);
        check("rst_edge1", 64'(if4.f), 64'h0);
        apply4(1'b1, 4'b1011, 4'b1111, 1'b1);
        check("rst_edge2", 64'(if4.f), 64'h0);
        apply4(1'b0, 4'b1011, 4'b1111, 1'b1);
        check("rst_release", 64'(if4.f), 64'hF);
        check("model_pin_release", 64'(e4), 64'hF);

        // Select a, then b with the data unchanged
        apply4(1'b0, 4'b1011, 4'b1111, 1'b0);
        check("sel_a", 64'(if4.f), 64'hB);
        apply4(1'b0, 4'b1011, 4'b1111, 1'b1);
        check("sel_b", 64'(if4.f), 64'hF);

        // Bit 0 is the MSB
        apply4(1'b0, 4'b0000, 4'b1000, 1'b0);
        check("msb_sel_a", 64'(if4.f), 64'h0);
        apply4(1'b0, 4'b0000, 4'b1000, 1'b1);
        check("msb_sel_b", 64'(if4.f), 64'h8);
        check("msb_index0", 64'(if4.f[0]), 64'h1);

        // Toggle sel every cycle
        for (int k = 0; k < 8; k++) begin
            apply4(1'b0, 4'b0101, 4'b1010, k[0]);
            check("toggle", 64'(if4.f), k[0] ? 64'hA : 64'h5);
        end

        // Mid-stream reset discards the in-flight selection
        apply4(1'b0, 4'b0110, 4'b1000, 1'b1);
        check("mid_pre", 64'(if4.f), 64'h8);
        apply4(1'b1, 4'b0110, 4'b1000, 1'b1);
        check("mid_rst", 64'(if4.f), 64'h0);
        check("model_pin_rst", 64'(e4), 64'h0);
        apply4(1'b0, 4'b0110, 4'b1000, 1'b1);
        check("mid_after", 64'(if4.f), 64'h8);

        // Random sweep on all widths, with occasional reset
        for (int n = 0; n < 1000; n++) begin
            rst     = ($urandom_range(0, 15) == 0);
            if4.a   = 4'($urandom);
            if4.b   = 4'($urandom);
            if4.sel = 1'($urandom);
            if1.a   = 1'($urandom);
            if1.b   = 1'($urandom);
            if1.sel = 1'($urandom);
            if8.a   = 8'($urandom);
            if8.b   = 8'($urandom);
            if8.sel = 1'($urandom);
            @(posedge clk);
            #1;
        end

        rst = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
